sch_pkt_desc_rd: RTL and testbench

- Read-side engine for the scheduler packet-descriptor FIFO. Pops meta_package::sch_pkt_desc_type entries from the FIFO head and forwards them on a registered valid/ready port to the scheduler datapath.
- Dispatch is gated by a downstream credit counter. A flush mode drains and discards queued descriptors (queue teardown / port disable).

---
 rtl/sch_pkt_desc_rd.sv | 160 ++++++++++++++++
 tb/tb_sch_pkt_desc_rd.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sch_pkt_desc_rd.sv
// sch_pkt_desc_rd: credit-gated read engine for the scheduler descriptor FIFO.
// Define SCH_PKT_DESC_RD_STATS_EN to add dispatch/drop counters.
package meta_package;
   typedef struct packed {
      logic [7:0]  qid;
      logic [13:0] len;
      logic [9:0]  ptr;
   } sch_pkt_desc_type;
endpackage

module sch_pkt_desc_rd
   import meta_package::*;
#(
   parameter int CREDIT_NBITS = 4,
   parameter int INIT_CREDITS = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   enable,
   input  logic                   flush,
   input  logic                   fifo_empty,
   input  sch_pkt_desc_type       fifo_dout,
   output logic                   fifo_rd,
   output logic                   desc_valid,
   input  logic                   desc_ready,
   output sch_pkt_desc_type       desc,
   input  logic                   credit_ret,
   output logic [CREDIT_NBITS:0]  credit_cnt,
   output logic                   flush_done,
   output logic                   busy
`ifdef SCH_PKT_DESC_RD_STATS_EN
   ,
   output logic [31:0]            disp_cnt,
   output logic [31:0]            drop_cnt
`endif
);

   localparam int CW = CREDIT_NBITS + 1;
   localparam logic [CW-1:0] CRED_MAX  = CW'(1) << CREDIT_NBITS;
   localparam logic [CW-1:0] CRED_INIT = CW'(INIT_CREDITS);
   localparam logic [CW-1:0] CRED_ONE  = CW'(1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FLUSH
   } state_t;

   state_t state;

   logic has_room;
   logic run_pop;
   logic flush_pop;
   logic accept;

   assign has_room = ~desc_valid | desc_ready;
   assign accept   = desc_valid & desc_ready;

   always_comb begin
      fifo_rd = 1'b0;
      unique case (1'b1)
         (state == RUN):
            fifo_rd = ~fifo_empty & (credit_cnt != '0) & has_room;
         (state == FLUSH):
            fifo_rd = ~fifo_empty;
         default:
            fifo_rd = 1'b0;
      endcase
   end

   assign run_pop   = fifo_rd & (state == RUN);
   assign flush_pop = fifo_rd & (state == FLUSH);

   assign busy = (state != IDLE) | desc_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         desc_valid <= 1'b0;
         desc       <= '0;
         credit_cnt <= CRED_INIT;
         flush_done <= 1'b0;
      end else begin
         flush_done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (flush)
                  state <= FLUSH;
               else if (enable)
                  state <= RUN;
            end
            RUN: begin
               if (flush)
                  state <= FLUSH;
               else if (!enable)
                  state <= IDLE;
            end
            FLUSH: begin
               if (!flush && fifo_empty && !fifo_rd) begin
                  state      <= IDLE;
                  flush_done <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase

         // a pending output survives mode changes until accepted
         if (run_pop) begin
            desc       <= fifo_dout;
            desc_valid <= 1'b1;
         end else if (accept) begin
            desc_valid <= 1'b0;
         end

         unique case ({run_pop, credit_ret})
            2'b10:
               credit_cnt <= credit_cnt - CRED_ONE;
            2'b01:
               if (credit_cnt != CRED_MAX)
                  credit_cnt <= credit_cnt + CRED_ONE;
            default: ;
         endcase
      end
   end

`ifdef SCH_PKT_DESC_RD_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         disp_cnt <= '0;
         drop_cnt <= '0;
      end else begin
         if (accept)
            disp_cnt <= disp_cnt + 32'd1;
         if (flush_pop)
            drop_cnt <= drop_cnt + 32'd1;
      end
   end
`else
   logic unused_flush_pop;
   assign unused_flush_pop = flush_pop;
`endif

`ifndef SYNTHESIS
   a_rd_empty: assert property (
      @(posedge clk) disable iff (!rst_n)
      !(fifo_rd && fifo_empty))
      else $error("sch_pkt_desc_rd: fifo_rd while fifo_empty");

   a_cred_ovf: assert property (
      @(posedge clk) disable iff (!rst_n)
      !(credit_ret && !run_pop && credit_cnt == CRED_MAX))
      else $error("sch_pkt_desc_rd: credit overflow");

   a_hold: assert property (
      @(posedge clk) disable iff (!rst_n)
      (desc_valid && !desc_ready) |=> $stable(desc))
      else $error("sch_pkt_desc_rd: desc changed while stalled");
`endif

endmodule

// File: tb/tb_sch_pkt_desc_rd.sv
// Directed bench for sch_pkt_desc_rd with a per-cycle reference model.
// Honors SCH_PKT_DESC_RD_STATS_EN to check the optional counters.
`timescale 1ns/1ps
module tb_sch_pkt_desc_rd;
   import meta_package::*;

   localparam int CN   = 4;
   localparam int INIT = 8;
   localparam int CMAX = 16;
   localparam int M_IDLE  = 0;
   localparam int M_RUN   = 1;
   localparam int M_FLUSH = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic enable = 1'b0;
   logic flush = 1'b0;
   logic desc_ready = 1'b0;
   logic credit_ret = 1'b0;
   logic fifo_empty;
   sch_pkt_desc_type fifo_dout;
   logic fifo_rd;
   logic desc_valid;
   sch_pkt_desc_type desc;
   logic [CN:0] credit_cnt;
   logic flush_done;
   logic busy;
`ifdef SCH_PKT_DESC_RD_STATS_EN
   logic [31:0] disp_cnt;
   logic [31:0] drop_cnt;
`endif

   always #5 clk = ~clk;

   sch_pkt_desc_rd #(.CREDIT_NBITS(CN), .INIT_CREDITS(INIT)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .enable(enable),
      .flush(flush),
      .fifo_empty(fifo_empty),
      .fifo_dout(fifo_dout),
      .fifo_rd(fifo_rd),
      .desc_valid(desc_valid),
      .desc_ready(desc_ready),
      .desc(desc),
      .credit_ret(credit_ret),
      .credit_cnt(credit_cnt),
      .flush_done(flush_done),
      .busy(busy)
`ifdef SCH_PKT_DESC_RD_STATS_EN
      ,
      .disp_cnt(disp_cnt),
      .drop_cnt(drop_cnt)
`endif
   );

   // fall-through FIFO, cleared by the shared reset
   sch_pkt_desc_type mem [256];
   logic [7:0] head = 8'd0;
   logic [7:0] tail = 8'd0;
   assign fifo_empty = (head == tail);
   assign fifo_dout  = mem[head];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         head <= tail;
      else if (fifo_rd)
         head <= head + 8'd1;
   end

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // reference model state
   sch_pkt_desc_type mq[$];
   sch_pkt_desc_type got[$];
   int m_mode = M_IDLE;
   int m_cred = INIT;
   logic m_valid = 1'b0;
   logic m_done = 1'b0;
   sch_pkt_desc_type m_desc = '0;
   int m_disp = 0;
   int m_drop = 0;
   int rd_cnt = 0;
   int done_cnt = 0;

   function automatic sch_pkt_desc_type mk(input int tag);
      logic [31:0] v;
      v = 32'h5A00_0000 + tag * 32'h0001_0203;
      return sch_pkt_desc_type'(v);
   endfunction

   task automatic push(input sch_pkt_desc_type d);
      mem[tail] = d;
      tail = tail + 8'd1;
      mq.push_back(d);
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   always begin
      bit empty;
      bit exp_rd;
      bit acc;
      @(negedge clk);
      #4;
      if (!rst_n) begin
         m_mode = M_IDLE; m_cred = INIT; m_valid = 1'b0;
         m_done = 1'b0; m_desc = '0; m_disp = 0; m_drop = 0;
         mq.delete();
         chk("rst_valid", desc_valid, 0);
         chk("rst_rd", fifo_rd, 0);
         chk("rst_cred", credit_cnt, INIT);
         chk("rst_desc", desc, 0);
         chk("rst_done", flush_done, 0);
      end else begin
         empty = (mq.size() == 0);
         if (m_mode == M_RUN)
            exp_rd = !empty && m_cred > 0 && (!m_valid || desc_ready);
         else if (m_mode == M_FLUSH)
            exp_rd = !empty;
         else
            exp_rd = 1'b0;
         chk("fifo_rd", fifo_rd, exp_rd);
         chk("desc_valid", desc_valid, m_valid);
         chk("desc", desc, m_desc);
         chk("credit_cnt", credit_cnt, m_cred);
         chk("flush_done", flush_done, m_done);
         chk("busy", busy, (m_mode != M_IDLE) || m_valid);
`ifdef SCH_PKT_DESC_RD_STATS_EN
         chk("disp_cnt", disp_cnt, m_disp);
         chk("drop_cnt", drop_cnt, m_drop);
`endif
         if (desc_valid && desc_ready) got.push_back(desc);
         if (fifo_rd) rd_cnt++;
         if (flush_done) done_cnt++;

         acc = m_valid && desc_ready;
         if (acc) m_disp++;
         if (exp_rd && m_mode == M_RUN) begin
            m_desc = mq.pop_front();
            m_valid = 1'b1;
            m_cred--;
         end else begin
            if (exp_rd) begin
               void'(mq.pop_front());
               m_drop++;
            end
            if (acc) m_valid = 1'b0;
         end
         if (credit_ret && m_cred < CMAX) m_cred++;
         m_done = (m_mode == M_FLUSH) && !flush && empty;
         case (m_mode)
            M_IDLE:  m_mode = flush ? M_FLUSH : (enable ? M_RUN : M_IDLE);
            M_RUN:   m_mode = flush ? M_FLUSH : (!enable ? M_IDLE : M_RUN);
            default: m_mode = (!flush && empty) ? M_IDLE : M_FLUSH;
         endcase
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: run did not finish");
      $fatal(1);
   end

   initial begin
      int rd0;
      int d0;
      #1 rst_n = 1'b0;
      cyc(3); #1;
      chk("lit_rst_cred", credit_cnt, 8);
      chk("lit_rst_busy", busy, 0);

      // A,B,C back to back
      cyc(1);
      rst_n = 1'b1; enable = 1'b1; desc_ready = 1'b1;
      push(mk(1)); push(mk(2)); push(mk(3));
      rd0 = rd_cnt;
      cyc(6); #1;
      chk("lit_abc_n", got.size(), 3);
      chk("lit_a", got[0], mk(1));
      chk("lit_b", got[1], mk(2));
      chk("lit_c", got[2], mk(3));
      chk("lit_abc_cred", credit_cnt, 5);
      chk("lit_abc_rd", rd_cnt - rd0, 3);

      // exhaust credits
      for (int i = 0; i < 7; i++) push(mk(16 + i));
      cyc(10); #1;
      chk("lit_cred0", credit_cnt, 0);
      chk("lit_cred0_n", got.size(), 8);
      chk("lit_cred0_rd", fifo_rd, 0);
      chk("lit_cred0_ne", fifo_empty, 0);
      cyc(1); credit_ret = 1'b1;
      cyc(1); credit_ret = 1'b0;
      cyc(4); #1;
      chk("lit_ret1_n", got.size(), 9);
      chk("lit_ret1_d", got[8], mk(21));
      chk("lit_ret1_cred", credit_cnt, 0);

      // stall hold, then back-to-back with pop+return at 3
      cyc(1);
      desc_ready = 1'b0; push(mk(40)); credit_ret = 1'b1;
      cyc(4); credit_ret = 1'b0;
      cyc(5); #1;
      chk("lit_hold_d", desc, mk(22));
      chk("lit_hold_v", desc_valid, 1);
      chk("lit_hold_cred", credit_cnt, 3);
      chk("lit_hold_rd", fifo_rd, 0);
      cyc(1); desc_ready = 1'b1; credit_ret = 1'b1;
      cyc(1); credit_ret = 1'b0; #1;
      chk("lit_b2b_d", desc, mk(40));
      chk("lit_b2b_v", desc_valid, 1);
      chk("lit_b2b_cred", credit_cnt, 3);
      chk("lit_b2b_acc", got[$], mk(22));
      cyc(2); #1;
      chk("lit_b2b_end", desc_valid, 0);
      chk("lit_b2b_n", got.size(), 11);

      // fill credits to the maximum
      cyc(1); credit_ret = 1'b1;
      cyc(13); credit_ret = 1'b0; #1;
      chk("lit_cred_max", credit_cnt, 16);

      // flush with pending output E
      cyc(1); desc_ready = 1'b0; push(mk(50));
      cyc(3); #1;
      chk("lit_e_d", desc, mk(50));
      chk("lit_e_cred", credit_cnt, 15);
      cyc(1);
      for (int i = 0; i < 6; i++) push(mk(80 + i));
      rd0 = rd_cnt;
      flush = 1'b1;
      cyc(9); #1;
      chk("lit_fl_pops", rd_cnt - rd0, 6);
      chk("lit_fl_cred", credit_cnt, 15);
      chk("lit_fl_d", desc, mk(50));
      chk("lit_fl_v", desc_valid, 1);
      chk("lit_fl_empty", fifo_empty, 1);
      d0 = done_cnt;
      cyc(1); enable = 1'b0; flush = 1'b0;
      cyc(3); #1;
      chk("lit_fl_done", done_cnt - d0, 1);
      chk("lit_fl_busy", busy, 1);
`ifdef SCH_PKT_DESC_RD_STATS_EN
      chk("lit_drop", drop_cnt, 6);
`endif
      cyc(1); desc_ready = 1'b1;
      cyc(2); #1;
      chk("lit_idle_busy", busy, 0);
      chk("lit_e_acc", got[$], mk(50));
      chk("lit_tot_n", got.size(), 12);
`ifdef SCH_PKT_DESC_RD_STATS_EN
      chk("lit_disp", disp_cnt, 12);
`endif

      // reset mid-burst
      cyc(1); enable = 1'b1;
      for (int i = 0; i < 4; i++) push(mk(60 + i));
      cyc(3);
      rst_n = 1'b0; #1;
      chk("lit_ar_v", desc_valid, 0);
      chk("lit_ar_rd", fifo_rd, 0);
      chk("lit_ar_cred", credit_cnt, 8);
      chk("lit_ar_d", desc, 0);
      enable = 1'b0;
      cyc(2); rst_n = 1'b1;
      cyc(3); #1;
      chk("lit_pr_busy", busy, 0);
      cyc(1); push(mk(70));
      cyc(3); #1;
      chk("lit_pr_rd", fifo_rd, 0);
      chk("lit_pr_v", desc_valid, 0);
      cyc(1); enable = 1'b1;
      cyc(4); #1;
      chk("lit_h_acc", got[$], mk(70));
      chk("lit_h_cred", credit_cnt, 7);
`ifdef SCH_PKT_DESC_RD_STATS_EN
      chk("lit_h_disp", disp_cnt, 1);
      chk("lit_h_drop", drop_cnt, 0);
`endif
      cyc(2);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
